// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers for the decoder front end: state encoding,
// saturation bounds and the wide-accumulator to BITSIZE conversion.
package fxp_pkg;

  localparam int unsigned FRAC_BITS_DEF = 12;
  localparam int unsigned WIDE_W        = 128;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {
    S_LOAD,
    S_MAC,
    S_OUT
  } state_t;

  function automatic wide_t sat_max(input int unsigned bitsize);
    return (wide_t'(1) <<< (bitsize - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int unsigned bitsize);
    return -(wide_t'(1) <<< (bitsize - 1));
  endfunction

  // Floor the accumulator by frac_bits, then clamp to the signed bitsize range.
  function automatic wide_t sat_trunc(input wide_t       acc,
                                      input int unsigned bitsize,
                                      input int unsigned frac_bits);
    wide_t y;
    y = acc >>> frac_bits;
    if (y > sat_max(bitsize)) begin
      y = sat_max(bitsize);
    end else if (y < sat_min(bitsize)) begin
      y = sat_min(bitsize);
    end
    return y;
  endfunction

endpackage

// File: rtl/fxp_mac_unit.sv
// Two-stage multiply-accumulate: registered product (or bias scaled to the
// product's binary point), then accumulation into a non-overflowing register.
module fxp_mac_unit #(
  parameter int unsigned BITSIZE   = 20,
  parameter int unsigned FRAC_BITS = 12,
  parameter int unsigned ACC_W     = 43
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    bias_sel,
  input  logic signed [BITSIZE-1:0] a,
  input  logic signed [BITSIZE-1:0] b,
  output logic signed [ACC_W-1:0]   acc
);

  localparam int unsigned PW = 2 * BITSIZE;

  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    prod_d;
  logic                    prod_vld;
  logic signed [ACC_W-1:0] acc_q;

  always_comb begin
    prod_d = bias_sel ? (PW'(b) <<< FRAC_BITS) : (PW'(a) * PW'(b));
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc_q    <= '0;
    end else begin
      prod_vld <= en;
      if (en) begin
        prod <= prod_d;
      end
      acc_q <= acc;
    end
  end

  // Exposes the sum including the pending product so the final term can be
  // saturated and registered in the same cycle it is accumulated.
  assign acc = prod_vld ? (acc_q + ACC_W'(prod)) : acc_q;

endmodule

// File: rtl/latent_dense_seq.sv
// Sequential dense layer after the reparameterisation stage: buffers N_IN
// latent samples, then streams N_OUT saturated neuron outputs.
// Optional build macro DEC_RELU_EN clamps negative outputs to zero.
module latent_dense_seq
  import fxp_pkg::*;
#(
  parameter int unsigned BITSIZE   = 20,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
  parameter int unsigned N_IN      = 8,
  parameter int unsigned N_OUT     = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [BITSIZE-1:0]                   in_data,
  output logic                                 in_ready,
  output logic [$clog2(N_OUT*(N_IN+1))-1:0]    w_addr,
  input  logic [BITSIZE-1:0]                   w_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BITSIZE-1:0]                   out_data,
  output logic                                 out_last
);

  localparam int unsigned ACC_W = 2 * BITSIZE + $clog2(N_IN + 1);
  localparam int unsigned IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned CW    = $clog2(N_IN + 3);
  localparam int unsigned JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [CW-1:0] C_NIN  = CW'(N_IN);
  localparam logic [CW-1:0] C_BIAS = CW'(N_IN + 1);
  localparam logic [CW-1:0] C_DONE = CW'(N_IN + 2);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  state_t state, state_nxt;

  logic [IW-1:0]             i_cnt;
  logic [CW-1:0]             c_cnt;
  logic [JW-1:0]             j_cnt;
  logic signed [BITSIZE-1:0] z_buf [N_IN];
  logic [IW-1:0]             k_idx;
  logic signed [BITSIZE-1:0] z_sel;
  logic                      load_last;
  logic                      out_fire;
  logic                      mac_clr;
  logic                      mac_en;
  logic                      mac_bias;
  logic signed [ACC_W-1:0]   acc;
  logic [BITSIZE-1:0]        y_out;

  assign in_ready  = (state == S_LOAD);
  assign load_last = in_ready & in_valid & (i_cnt == I_LAST);
  assign out_fire  = (state == S_OUT) & out_ready;
  assign mac_clr   = load_last | out_fire;
  assign mac_en    = (state == S_MAC) & (c_cnt != '0) & (c_cnt <= C_BIAS);
  assign mac_bias  = (c_cnt == C_BIAS);

  // Coefficient for address k arrives one cycle later, so z is indexed by c-1.
  always_comb begin
    k_idx = IW'(c_cnt - CW'(1));
    z_sel = '0;
    if ((c_cnt != '0) && (c_cnt <= C_NIN)) begin
      z_sel = z_buf[k_idx];
    end
  end

  always_comb begin
    y_out = BITSIZE'(sat_trunc(wide_t'(acc), BITSIZE, FRAC_BITS));
`ifdef DEC_RELU_EN
    if (y_out[BITSIZE-1]) begin
      y_out = '0;
    end
`endif
  end

  fxp_mac_unit #(
    .BITSIZE  (BITSIZE),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr     (mac_clr),
    .en      (mac_en),
    .bias_sel(mac_bias),
    .a       (z_sel),
    .b       (w_data),
    .acc     (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_LOAD: if (load_last) state_nxt = S_MAC;
      S_MAC:  if (c_cnt == C_DONE) state_nxt = S_OUT;
      S_OUT:  if (out_ready) state_nxt = (j_cnt == J_LAST) ? S_LOAD : S_MAC;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_cnt     <= '0;
      c_cnt     <= '0;
      j_cnt     <= '0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      for (int unsigned n = 0; n < N_IN; n++) begin
        z_buf[IW'(n)] <= '0;
      end
    end else begin
      unique case (state)
        S_LOAD: begin
          if (in_valid) begin
            z_buf[i_cnt] <= in_data;
            i_cnt        <= load_last ? '0 : i_cnt + 1'b1;
          end
        end
        S_MAC: begin
          if (c_cnt < C_NIN) begin
            w_addr <= w_addr + 1'b1;
          end
          if (c_cnt == C_DONE) begin
            out_data  <= y_out;
            out_valid <= 1'b1;
            out_last  <= (j_cnt == J_LAST);
          end else begin
            c_cnt <= c_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            c_cnt     <= '0;
            if (j_cnt == J_LAST) begin
              j_cnt  <= '0;
              i_cnt  <= '0;
              w_addr <= '0;
            end else begin
              j_cnt  <= j_cnt + 1'b1;
              // w_addr rests on this neuron's bias, so +1 is the next neuron's base.
              w_addr <= w_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
